// File: rtl/sram_test_seq.sv
`default_nettype none
// ============================================================================
// Module   : sram_test_seq
// Purpose  : Key-driven access sequencer sitting upstream of the SRAM
//            controller. Debounces four active-low board keys and drives the
//            controller with write/read request pulses, address and write data.
//            key0 runs a write-then-verify pattern pass, key1 performs a single
//            read, key2 steps the address and key3 aborts. Read data and
//            pass/fail status are presented for the seg display.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            key_in[3:0]         - raw keys, 0 = pressed
//            wr_request/rd_request - 1-cycle request pulses to the controller
//            addr, wr_data       - held from request until ctrl_done
//            ctrl_done, rd_data  - controller completion pulse and read byte
//            disp_data, err_cnt  - last read byte, saturating mismatch count
//            busy, pass, fail    - activity and last-pass status
// Config   : define SRAM_SEQ_TIMEOUT_EN to bound every wait on ctrl_done by
//            TIMEOUT_CYC cycles (timeout forces fail=1).
// Revision : 1.0 - initial release
// ============================================================================
module sram_test_seq #(
    parameter int         ADDR_W      = 17,
    parameter int         DATA_W      = 8,
    parameter int         DEB_CYCLES  = 500000,
    parameter int         TEST_LEN    = 256,
    parameter logic [7:0] SEED        = 8'hC3,
    parameter int         TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        key_in,
    output logic              wr_request,
    output logic              rd_request,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              ctrl_done,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] disp_data,
    output logic [7:0]        err_cnt,
    output logic              busy,
    output logic              pass,
    output logic              fail
);

    localparam int                c_DEB_W = $clog2(DEB_CYCLES + 1);
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(TEST_LEN - 1);

    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_WR_REQ   = 3'd1;
    localparam logic [2:0] c_S_WR_WAIT  = 3'd2;
    localparam logic [2:0] c_S_RD_REQ   = 3'd3;
    localparam logic [2:0] c_S_RD_WAIT  = 3'd4;
    localparam logic [2:0] c_S_SRD_REQ  = 3'd5;
    localparam logic [2:0] c_S_SRD_WAIT = 3'd6;
    localparam logic [2:0] c_S_DONE     = 3'd7;

    // ------------------------------------------------------------------
    // Key synchroniser and debounce
    // ------------------------------------------------------------------
    logic [3:0] r_key_meta, r_key_sync, r_key_last;
    logic [3:0] w_key_press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_meta <= 4'hF;
            r_key_sync <= 4'hF;
            r_key_last <= 4'hF;
        end else begin
            r_key_meta <= key_in;
            r_key_sync <= r_key_meta;
            r_key_last <= r_key_sync;
        end
    end

    generate
        for (genvar k = 0; k < 4; k++) begin : g_deb
            logic [c_DEB_W-1:0] r_cnt;
            logic               r_stable;
            logic               r_press;

            // The counter only advances while the synchronised level is
            // steady and differs from the accepted level; any change restarts it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt    <= '0;
                    r_stable <= 1'b1;
                    r_press  <= 1'b0;
                end else begin
                    r_press <= 1'b0;
                    if ((r_key_sync[k] != r_key_last[k]) || (r_key_sync[k] == r_stable)) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DEB_W'(DEB_CYCLES - 1)) begin
                        r_cnt    <= '0;
                        r_stable <= r_key_sync[k];
                        r_press  <= ~r_key_sync[k];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_key_press[k] = r_press;
        end
    endgenerate

    logic w_ev_abort, w_ev_start, w_ev_read, w_ev_inc;
    assign w_ev_abort = w_key_press[3];
    assign w_ev_start = w_key_press[0];
    assign w_ev_read  = w_key_press[1];
    assign w_ev_inc   = w_key_press[2];

    // ------------------------------------------------------------------
    // Address / pattern helpers
    // ------------------------------------------------------------------
    logic [2:0]        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wr_data, r_disp_data;
    logic [7:0]        r_err_cnt;
    logic              r_pass, r_fail;

    logic              w_last;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [DATA_W-1:0] w_expect, w_pat_inc;
    logic [7:0]        w_err_nxt;
    logic              w_timeout;

    assign w_last     = (r_addr == c_LAST);
    assign w_addr_inc = w_last ? '0 : r_addr + 1'b1;
    assign w_expect   = DATA_W'(r_addr[7:0] ^ SEED);
    assign w_pat_inc  = DATA_W'(w_addr_inc[7:0] ^ SEED);
    assign w_err_nxt  = ((rd_data != w_expect) && (r_err_cnt != 8'hFF)) ? r_err_cnt + 8'd1
                                                                         : r_err_cnt;

`ifdef SRAM_SEQ_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYC + 1);
    logic              w_in_wait;
    logic [c_TO_W-1:0] r_wait_cnt;

    assign w_in_wait = (r_state == c_S_WR_WAIT) || (r_state == c_S_RD_WAIT) ||
                       (r_state == c_S_SRD_WAIT);
    assign w_timeout = w_in_wait && !ctrl_done && (r_wait_cnt == c_TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (!w_in_wait || ctrl_done || w_timeout) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    logic w_wr_req, w_rd_req, w_busy;

    always_comb begin
        w_state_nxt = r_state;
        w_wr_req    = 1'b0;
        w_rd_req    = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            c_S_IDLE, c_S_DONE: begin
                w_busy = 1'b0;
                if (w_ev_start)     w_state_nxt = c_S_WR_REQ;
                else if (w_ev_read) w_state_nxt = c_S_SRD_REQ;
            end
            c_S_WR_REQ: begin
                w_wr_req    = 1'b1;
                w_state_nxt = c_S_WR_WAIT;
            end
            c_S_WR_WAIT: begin
                if (ctrl_done)      w_state_nxt = w_last ? c_S_RD_REQ : c_S_WR_REQ;
                else if (w_timeout) w_state_nxt = c_S_DONE;
            end
            c_S_RD_REQ: begin
                w_rd_req    = 1'b1;
                w_state_nxt = c_S_RD_WAIT;
            end
            c_S_RD_WAIT: begin
                if (ctrl_done)      w_state_nxt = w_last ? c_S_DONE : c_S_RD_REQ;
                else if (w_timeout) w_state_nxt = c_S_DONE;
            end
            c_S_SRD_REQ: begin
                w_rd_req    = 1'b1;
                w_state_nxt = c_S_SRD_WAIT;
            end
            c_S_SRD_WAIT: begin
                if (ctrl_done || w_timeout) w_state_nxt = c_S_IDLE;
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
        // Abort beats everything, including a ctrl_done in the same cycle.
        if (w_ev_abort) w_state_nxt = c_S_IDLE;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_wr_data   <= '0;
            r_disp_data <= '0;
            r_err_cnt   <= '0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
        end else if (!w_ev_abort) begin
            case (r_state)
                c_S_IDLE, c_S_DONE: begin
                    if (w_ev_start) begin
                        r_addr    <= '0;
                        r_wr_data <= DATA_W'(SEED);
                        r_err_cnt <= '0;
                        r_pass    <= 1'b0;
                        r_fail    <= 1'b0;
                    end else if (!w_ev_read && w_ev_inc) begin
                        r_addr <= w_addr_inc;
                    end
                end
                c_S_WR_WAIT: begin
                    if (ctrl_done) begin
                        // Wrap to 0 on the last write so the verify phase starts at 0.
                        r_addr    <= w_addr_inc;
                        r_wr_data <= w_pat_inc;
                    end else if (w_timeout) begin
                        r_fail <= 1'b1;
                        r_pass <= 1'b0;
                    end
                end
                c_S_RD_WAIT: begin
                    if (ctrl_done) begin
                        r_disp_data <= rd_data;
                        r_err_cnt   <= w_err_nxt;
                        if (w_last) begin
                            r_pass <= (w_err_nxt == 8'd0);
                            r_fail <= (w_err_nxt != 8'd0);
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_fail <= 1'b1;
                        r_pass <= 1'b0;
                    end
                end
                c_S_SRD_WAIT: begin
                    if (ctrl_done)      r_disp_data <= rd_data;
                    else if (w_timeout) r_fail      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign wr_request = w_wr_req;
    assign rd_request = w_rd_req;
    assign busy       = w_busy;
    assign addr       = r_addr;
    assign wr_data    = r_wr_data;
    assign disp_data  = r_disp_data;
    assign err_cnt    = r_err_cnt;
    assign pass       = r_pass;
    assign fail       = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_sram_test_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_test_seq
// Purpose  : Self-checking bench for sram_test_seq with a short debounce time
//            and a behavioural SRAM controller that answers each request with
//            ctrl_done three cycles later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_test_seq;

    localparam int DEB  = 24;
    localparam int HOLD = DEB + 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key_in = 4'hF;
    logic        wr_request, rd_request;
    logic [16:0] addr;
    logic [7:0]  wr_data;
    logic        ctrl_done = 1'b0;
    logic [7:0]  rd_data   = 8'h00;
    logic [7:0]  disp_data;
    logic [7:0]  err_cnt;
    logic        busy, pass, fail;

    sram_test_seq #(
        .ADDR_W(17), .DATA_W(8), .DEB_CYCLES(DEB), .TEST_LEN(256),
        .SEED(8'hC3), .TIMEOUT_CYC(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in),
        .wr_request(wr_request), .rd_request(rd_request),
        .addr(addr), .wr_data(wr_data),
        .ctrl_done(ctrl_done), .rd_data(rd_data),
        .disp_data(disp_data), .err_cnt(err_cnt),
        .busy(busy), .pass(pass), .fail(fail)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Controller model and protocol monitor
    // ------------------------------------------------------------------
    logic [7:0]  mem [0:255];
    bit          corrupt [0:255];
    int          stall_addr = -1;
    int          wr_total = 0, rd_total = 0, wd_err = 0, proto_err = 0;
    logic [16:0] last_rd_addr = '0;
    logic        pend = 1'b0, pend_rd = 1'b0, prev_req = 1'b0;
    logic [16:0] pend_addr = '0;
    logic [7:0]  pend_wdata = '0;
    int          dly = 0;

    always @(posedge clk) begin
        ctrl_done <= 1'b0;
        prev_req  <= wr_request | rd_request;
        if (wr_request && rd_request) proto_err <= proto_err + 1;
        if ((wr_request || rd_request) && prev_req) proto_err <= proto_err + 1;
        if (pend && ((addr != pend_addr) || (!pend_rd && (wr_data != pend_wdata))))
            proto_err <= proto_err + 1;
        if (wr_request || rd_request) begin
            if (wr_request) begin
                wr_total <= wr_total + 1;
                mem[addr[7:0]] <= wr_data;
                if (wr_data != (addr[7:0] ^ 8'hC3)) wd_err <= wd_err + 1;
            end else begin
                rd_total     <= rd_total + 1;
                last_rd_addr <= addr;
            end
            if (int'(addr) != stall_addr) begin
                pend       <= 1'b1;
                pend_rd    <= rd_request;
                pend_addr  <= addr;
                pend_wdata <= wr_data;
                dly        <= 2;
            end
        end else if (pend) begin
            if (dly == 1) begin
                ctrl_done <= 1'b1;
                rd_data   <= mem[pend_addr[7:0]] ^ ((pend_rd && corrupt[pend_addr[7:0]]) ? 8'hFF : 8'h00);
                pend      <= 1'b0;
            end
            dly <= dly - 1;
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input int k);
        key_in[k] = 1'b0;
        repeat (HOLD) @(negedge clk);
        key_in[k] = 1'b1;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, " idle"}, busy, 0);
    endtask

    typedef struct {
        string      name;
        int         bad_a;
        int         bad_b;
        logic [7:0] exp_err;
        logic       exp_pass;
        logic       exp_fail;
        logic [7:0] exp_disp;
    } pass_vec_t;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        pass_vec_t vecs[3];
        int w0, r0, w1, r1;

        vecs[0] = '{"clean",    -1,  -1, 8'd0, 1'b1, 1'b0, 8'h3C};
        vecs[1] = '{"bad5_200",  5, 200, 8'd2, 1'b0, 1'b1, 8'h3C};
        vecs[2] = '{"bad255",  255,  -1, 8'd1, 1'b0, 1'b1, 8'hC3};
        for (int a = 0; a < 256; a++) corrupt[a] = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst wr_request", wr_request, 0);
        check("rst rd_request", rd_request, 0);
        check("rst addr",       addr,       0);
        check("rst wr_data",    wr_data,    0);
        check("rst disp/err",   {disp_data, err_cnt}, 0);
        check("rst busy/pass/fail", {busy, pass, fail}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Full pattern passes from the vector table
        for (int v = 0; v < 3; v++) begin
            for (int a = 0; a < 256; a++) corrupt[a] = 1'b0;
            if (vecs[v].bad_a >= 0) corrupt[vecs[v].bad_a] = 1'b1;
            if (vecs[v].bad_b >= 0) corrupt[vecs[v].bad_b] = 1'b1;
            w0 = wr_total;
            r0 = rd_total;
            press(0);
            check({vecs[v].name, " busy"}, busy, 1);
            wait_idle(vecs[v].name, 4000);
            check({vecs[v].name, " err_cnt"}, err_cnt, vecs[v].exp_err);
            check({vecs[v].name, " pass"},    pass,    vecs[v].exp_pass);
            check({vecs[v].name, " fail"},    fail,    vecs[v].exp_fail);
            check({vecs[v].name, " disp"},    disp_data, vecs[v].exp_disp);
            check({vecs[v].name, " addr"},    addr,    255);
            check({vecs[v].name, " writes"},  wr_total - w0, 256);
            check({vecs[v].name, " reads"},   rd_total - r0, 256);
        end
        for (int a = 0; a < 256; a++) corrupt[a] = 1'b0;

        // Bouncing key0: short glitches must not register, then one clean press
        w0 = wr_total;
        r0 = rd_total;
        for (int t = 0; t < 24; t++) begin
            key_in[0] = ~key_in[0];
            repeat (10) @(negedge clk);
        end
        check("bounce no start busy", busy, 0);
        check("bounce no start wr", wr_total - w0, 0);
        press(0);
        wait_idle("bounce", 4000);
        repeat (100) @(negedge clk);
        check("bounce writes", wr_total - w0, 256);
        check("bounce reads",  rd_total - r0, 256);
        check("bounce pass",   pass, 1);

        // Address stepping with wrap, then a single read
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst2 addr", addr, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 1; i <= 257; i++) begin
            press(2);
            if (i == 255) check("key2 x255 addr", addr, 255);
            if (i == 256) check("key2 x256 wrap", addr, 0);
        end
        check("key2 x257 addr", addr, 1);
        w0 = wr_total;
        r0 = rd_total;
        press(1);
        check("sread reads",  rd_total - r0, 1);
        check("sread writes", wr_total - w0, 0);
        check("sread addr",   last_rd_addr, 1);
        check("sread disp",   disp_data, 8'hC2);
        check("sread busy/pass/fail", {busy, pass, fail}, 0);

        // Abort during a stalled write at address 10
        stall_addr = 10;
        w0 = wr_total;
        press(0);
        repeat (60) @(negedge clk);
`ifndef SRAM_SEQ_TIMEOUT_EN
        check("abort pre busy", busy, 1);
`endif
        check("abort pre writes", wr_total - w0, 11);
        check("abort pre addr", addr, 10);
        w1 = wr_total;
        r1 = rd_total;
        press(3);
        check("abort busy", busy, 0);
        check("abort addr", addr, 10);
        check("abort err_cnt", err_cnt, 0);
        repeat (50) @(negedge clk);
        check("abort no requests", (wr_total - w1) + (rd_total - r1), 0);
        stall_addr = -1;

        // Controller never answers; then asynchronous reset mid-pass
        stall_addr = 0;
        w0 = wr_total;
        press(0);
        repeat (200) @(negedge clk);
`ifdef SRAM_SEQ_TIMEOUT_EN
        check("timeout fail", fail, 1);
        check("timeout pass", pass, 0);
        check("timeout busy", busy, 0);
`else
        check("stall busy", busy, 1);
        check("stall fail", fail, 0);
`endif
        check("stall writes", wr_total - w0, 1);
        check("stall addr", addr, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst busy", busy, 0);
        check("async rst req", {wr_request, rd_request}, 0);
        check("async rst fail/err", {fail, err_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stall_addr = -1;
        w1 = wr_total + rd_total;
        repeat (50) @(negedge clk);
        check("post rst no requests", wr_total + rd_total - w1, 0);

        check("write data pattern", wd_err, 0);
        check("request protocol", proto_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
